// File: rtl/stack_arbiter.sv
// Two-client push/pop arbiter and sequencer for a LIFO stack.
// Define STACK_ARB_FIXED_PRIO_EN for fixed priority (client 0 first).
module stack_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic [1:0]       done,
  output logic             err,
  output logic [WIDTH-1:0] rdata,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_wdata,
  input  logic [WIDTH-1:0] stk_rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             op_q, op_d;
  logic             ill_q, ill_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]    count_q, count_d;
  logic             win;

`ifdef STACK_ARB_FIXED_PRIO_EN
  always_comb begin
    win = ~req[0];
  end
`else
  logic ptr_q, ptr_d;

  always_comb begin
    win = (req == 2'b11) ? ptr_q : req[1];
    ptr_d = ptr_q;
    if (state_q == IDLE && |req) begin
      ptr_d = ~win;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    ill_d   = ill_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = win;
          op_d    = op[win];
          wdata_d = win ? wdata1 : wdata0;
          ill_d   = op[win] ? full : empty;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!ill_q) begin
          if (op_q) begin
            count_d = count_q + CW'(1);
          end else begin
            count_d = count_q - CW'(1);
            rdata_d = stk_rdata;
          end
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      op_q    <= 1'b0;
      ill_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      count_q <= count_d;
    end
  end

  // Strobes and done are decoded from registered state only.
  always_comb begin
    stk_push  = (state_q == ISSUE) & op_q & ~ill_q;
    stk_pop   = (state_q == ISSUE) & ~op_q & ~ill_q;
    stk_wdata = wdata_q;
    done[0]   = (state_q == DONE) & ~gnt_q;
    done[1]   = (state_q == DONE) & gnt_q;
    err       = (state_q == DONE) & ill_q;
    rdata     = rdata_q;
    count     = count_q;
    full      = (count_q == FULL_C);
    empty     = (count_q == '0);
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboard bench for stack_arbiter with a small behavioural stack.
// Runs with DEPTH = 4 so the full boundary is reached quickly.
module tb_stack_arbiter;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req = '0;
  logic [1:0]    op = '0;
  logic [W-1:0]  wdata0 = '0;
  logic [W-1:0]  wdata1 = '0;
  logic [1:0]    done;
  logic          err;
  logic [W-1:0]  rdata;
  logic          stk_push;
  logic          stk_pop;
  logic [W-1:0]  stk_wdata;
  logic [W-1:0]  stk_rdata;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  stack_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(rst_n), .req(req), .op(op),
    .wdata0(wdata0), .wdata1(wdata1),
    .done(done), .err(err), .rdata(rdata),
    .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_push  = 0;
  int n_pop   = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (stk_push) n_push <= n_push + 1;
    if (stk_pop)  n_pop  <= n_pop + 1;
  end

  // Behavioural stack sharing the arbiter reset
  logic [W-1:0] mem [D];
  int sp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= 0;
    end else if (stk_push && sp < D) begin
      mem[sp] <= stk_wdata;
      sp <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      sp <= sp - 1;
    end
  end
  assign stk_rdata = (sp > 0) ? mem[sp-1] : '0;

  always @(negedge clk) begin
    if (rst_n) begin
      n_tests++;
      if ((stk_push & stk_pop) !== 1'b0) begin
        n_fail++;
        $display("FAIL strobe_excl: push=%b pop=%b", stk_push, stk_pop);
      end
      n_tests++;
      if (done === 2'b11 || $isunknown(done)) begin
        n_fail++;
        $display("FAIL done_onehot0: got %b", done);
      end
      n_tests++;
      if (count !== CW'(sp)) begin
        n_fail++;
        $display("FAIL count_tally: got %0d want %0d", count, sp);
      end
    end
  end

  typedef struct {
    int         client;
    logic       err;
    logic [W-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int mcnt;
  logic [W-1:0] mstk [D];
  logic [W-1:0] mrd;

  task automatic model_op(input int c, input bit o, input logic [W-1:0] d);
    exp_t e;
    e.client = c;
    e.err = 1'b0;
    if (o) begin
      if (mcnt == D) e.err = 1'b1;
      else begin
        mstk[mcnt] = d;
        mcnt++;
      end
    end else begin
      if (mcnt == 0) e.err = 1'b1;
      else begin
        mcnt--;
        mrd = mstk[mcnt];
      end
    end
    e.rdata = mrd;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    op = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mcnt = 0;
    mrd = '0;
    sb.delete();
    @(negedge clk);
  endtask

  task automatic access(input int c, input bit o, input logic [W-1:0] d,
                        output logic [1:0] od, output logic oe,
                        output logic [W-1:0] ord, output int lat,
                        output int dcyc);
    req[c] = 1'b1;
    op[c] = o;
    if (c == 0) wdata0 = d;
    else wdata1 = d;
    model_op(c, o, d);
    lat = 0;
    od = '0;
    oe = 1'b0;
    ord = '0;
    dcyc = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (done !== 2'b00) break;
    end
    if (done === 2'b00) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: client %0d no done", c);
    end else begin
      od = done;
      oe = err;
      ord = rdata;
      dcyc = cyc;
    end
    req[c] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({count, empty, full, done, err, rdata, stk_push, stk_pop, stk_wdata}
        !== {CW'(0), 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_vals: cnt=%0d e=%b f=%b d=%b err=%b rd=%h p=%b q=%b wd=%h want 0 1 0 00 0 00 0 0 00",
               count, empty, full, done, err, rdata, stk_push, stk_pop, stk_wdata);
    end
  endtask

  task automatic test_push_pop();
    logic [1:0] od; logic oe; logic [W-1:0] ord;
    int lat, dc, prev;
    exp_t e;
    do_reset();
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) access(0, 1'b1, W'(i + 1), od, oe, ord, lat, dc);
      else access(0, 1'b0, '0, od, oe, ord, lat, dc);
      e = sb.pop_front();
      n_tests++;
      if (od !== 2'b01 || oe !== e.err || ord !== e.rdata) begin
        n_fail++;
        $display("FAIL pushpop[%0d]: d=%b err=%b rd=%h want 01 %b %h",
                 i, od, oe, ord, e.err, e.rdata);
      end
      n_tests++;
      if (i == 0 && lat != 2 || i > 0 && dc - prev != 3) begin
        n_fail++;
        $display("FAIL pushpop_lat[%0d]: lat=%0d gap=%0d want 2/3", i, lat, dc - prev);
      end
      prev = dc;
      if (i == 2) begin
        n_tests++;
        if (count !== CW'(3)) begin
          n_fail++;
          $display("FAIL pushpop_cnt3: got %0d want 3", count);
        end
      end
    end
    n_tests++;
    if (count !== CW'(0) || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL pushpop_end: cnt=%0d empty=%b want 0 1", count, empty);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] od; logic oe; logic [W-1:0] ord;
    int lat, dc, prev, k;
    exp_t e;
    logic [1:0] xd;
    do_reset();
    req = 2'b11;
    op = 2'b11;
    wdata0 = 8'hA0;
    wdata1 = 8'hB0;
`ifdef STACK_ARB_FIXED_PRIO_EN
    model_op(0, 1'b1, 8'hA0);
    model_op(0, 1'b1, 8'hA0);
    model_op(1, 1'b1, 8'hB0);
    model_op(1, 1'b1, 8'hB0);
`else
    model_op(0, 1'b1, 8'hA0);
    model_op(1, 1'b1, 8'hB0);
    model_op(0, 1'b1, 8'hA0);
    model_op(1, 1'b1, 8'hB0);
`endif
    prev = 0;
    k = 0;
    for (int t = 0; t < 40 && k < 4; t++) begin
      @(negedge clk);
      if (done !== 2'b00) begin
        e = sb.pop_front();
        xd = (e.client == 1) ? 2'b10 : 2'b01;
        n_tests++;
        if (done !== xd || err !== e.err) begin
          n_fail++;
          $display("FAIL rr_grant[%0d]: d=%b err=%b want %b %b", k, done, err, xd, e.err);
        end
        if (k > 0) begin
          n_tests++;
          if (cyc - prev != 3) begin
            n_fail++;
            $display("FAIL rr_gap[%0d]: got %0d want 3", k, cyc - prev);
          end
        end
        prev = cyc;
`ifdef STACK_ARB_FIXED_PRIO_EN
        if (k == 1) req[0] = 1'b0;
`endif
        k++;
      end
    end
    req = 2'b00;
    n_tests++;
    if (k != 4) begin
      n_fail++;
      $display("FAIL rr_count: got %0d grants want 4", k);
    end
    n_tests++;
    if (count !== CW'(4) || full !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_full: cnt=%0d full=%b want 4 1", count, full);
    end
    @(negedge clk);
    access(1, 1'b0, '0, od, oe, ord, lat, dc);
    e = sb.pop_front();
    n_tests++;
    if (od !== 2'b10 || oe !== e.err || ord !== e.rdata) begin
      n_fail++;
      $display("FAIL rr_pop: d=%b err=%b rd=%h want 10 %b %h", od, oe, ord, e.err, e.rdata);
    end
  endtask

  task automatic test_full();
    logic [1:0] od; logic oe; logic [W-1:0] ord;
    int lat, dc, np;
    exp_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      np = n_push;
      access(0, 1'b1, W'(8'h11 + i), od, oe, ord, lat, dc);
      e = sb.pop_front();
      n_tests++;
      if (od !== 2'b01 || oe !== e.err || ord !== e.rdata) begin
        n_fail++;
        $display("FAIL full_push[%0d]: d=%b err=%b rd=%h want 01 %b %h",
                 i, od, oe, ord, e.err, e.rdata);
      end
      if (i == 4) begin
        n_tests++;
        if (n_push != np || count !== CW'(4) || full !== 1'b1) begin
          n_fail++;
          $display("FAIL full_reject: strobes=%0d cnt=%0d full=%b want 0 4 1",
                   n_push - np, count, full);
        end
      end
    end
    access(1, 1'b0, '0, od, oe, ord, lat, dc);
    e = sb.pop_front();
    n_tests++;
    if (od !== 2'b10 || oe !== e.err || ord !== e.rdata) begin
      n_fail++;
      $display("FAIL full_pop: d=%b err=%b rd=%h want 10 %b %h", od, oe, ord, e.err, e.rdata);
    end
  endtask

  task automatic test_empty();
    logic [1:0] od; logic oe; logic [W-1:0] ord;
    int lat, dc, np;
    exp_t e;
    do_reset();
    np = n_pop;
    access(1, 1'b0, '0, od, oe, ord, lat, dc);
    e = sb.pop_front();
    n_tests++;
    if (od !== 2'b10 || oe !== e.err || ord !== e.rdata) begin
      n_fail++;
      $display("FAIL empty_pop: d=%b err=%b rd=%h want 10 %b %h", od, oe, ord, e.err, e.rdata);
    end
    n_tests++;
    if (n_pop != np || count !== CW'(0)) begin
      n_fail++;
      $display("FAIL empty_state: strobes=%0d cnt=%0d want 0 0", n_pop - np, count);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] od; logic oe; logic [W-1:0] ord;
    int lat, dc;
    exp_t e;
    do_reset();
    req[0] = 1'b1;
    op[0] = 1'b1;
    wdata0 = 8'h5A;
    @(posedge clk);
    #1;
    n_tests++;
    if (stk_push !== 1'b1 || stk_wdata !== 8'h5A) begin
      n_fail++;
      $display("FAIL mid_issue: push=%b wd=%h want 1 5a", stk_push, stk_wdata);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (stk_push !== 1'b0 || done !== 2'b00 || count !== CW'(0)) begin
      n_fail++;
      $display("FAIL mid_reset: push=%b d=%b cnt=%0d want 0 00 0", stk_push, done, count);
    end
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mcnt = 0;
    mrd = '0;
    sb.delete();
    @(negedge clk);
    access(0, 1'b0, '0, od, oe, ord, lat, dc);
    e = sb.pop_front();
    n_tests++;
    if (od !== 2'b01 || oe !== 1'b1 || oe !== e.err || ord !== e.rdata) begin
      n_fail++;
      $display("FAIL mid_pop: d=%b err=%b rd=%h want 01 1 %h", od, oe, ord, e.rdata);
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_back_to_back();
    test_full();
    test_empty();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
